// File: rtl/snn_stim_tx_if.sv
// Host-side load/launch/result port and SNN-side stream/result port of the stimulus transmitter.
// The master side is the host/SNN environment; the transmitter uses the slave side.
interface snn_stim_tx_if;
    logic       ld_valid;
    logic [1:0] ld_sel;
    logic [6:0] ld_addr;
    logic [7:0] ld_data;
    logic       start;
    logic       busy;
    logic       in_valid;
    logic [7:0] img;
    logic [7:0] ker;
    logic [7:0] weight;
    logic       out_valid;
    logic [9:0] out_data;
    logic       res_valid;
    logic [9:0] res_data;
    logic       res_timeout;

    modport master (
        output ld_valid, ld_sel, ld_addr, ld_data, start, out_valid, out_data,
        input  busy, in_valid, img, ker, weight, res_valid, res_data, res_timeout
    );

    modport slave (
        input  ld_valid, ld_sel, ld_addr, ld_data, start, out_valid, out_data,
        output busy, in_valid, img, ker, weight, res_valid, res_data, res_timeout
    );
endinterface

// File: rtl/snn_stim_tx.sv
// Holds one SNN job (72 image, 9 kernel, 4 weight bytes), streams it on start,
// then waits for the SNN result or a timeout and reports it to the host.
module snn_stim_tx #(
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    snn_stim_tx_if.slave bus
);
    localparam int NBEAT = 72;
    localparam int WW    = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [7:0]    img_mem [NBEAT];
    logic [7:0]    ker_mem [9];
    logic [7:0]    w_mem   [4];
    logic [1:0]    state;
    logic [6:0]    beat;
    logic [WW-1:0] wcnt;

    logic       idle, wr_img, wr_ker, wr_w;
    logic [6:0] rd_idx;
    logic [7:0] img_nxt, ker_nxt, w_nxt;

    assign idle   = (state == S_IDLE);
    assign wr_img = idle && bus.ld_valid && bus.ld_sel == 2'd0 && bus.ld_addr < 7'd72;
    assign wr_ker = idle && bus.ld_valid && bus.ld_sel == 2'd1 && bus.ld_addr < 7'd9;
    assign wr_w   = idle && bus.ld_valid && bus.ld_sel == 2'd2 && bus.ld_addr < 7'd4;

    // Buffer is deliberately outside the reset domain so a job survives reset.
    always_ff @(posedge clk) begin
        if (wr_img) img_mem[bus.ld_addr]      <= bus.ld_data;
        if (wr_ker) ker_mem[bus.ld_addr[3:0]] <= bus.ld_data;
        if (wr_w)   w_mem[bus.ld_addr[1:0]]   <= bus.ld_data;
    end

    // Beat 0 is fetched on the start edge; a same-cycle write is forwarded so it is seen.
    assign rd_idx = idle ? 7'd0 : beat;

    always_comb begin
        img_nxt = 8'd0;
        ker_nxt = 8'd0;
        w_nxt   = 8'd0;
        if (rd_idx < 7'd72)
            img_nxt = (wr_img && bus.ld_addr == rd_idx) ? bus.ld_data : img_mem[rd_idx];
        if (rd_idx < 7'd9)
            ker_nxt = (wr_ker && bus.ld_addr == rd_idx) ? bus.ld_data : ker_mem[rd_idx[3:0]];
        if (rd_idx < 7'd4)
            w_nxt   = (wr_w && bus.ld_addr == rd_idx) ? bus.ld_data : w_mem[rd_idx[1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            beat            <= 7'd0;
            wcnt            <= '0;
            bus.busy        <= 1'b0;
            bus.in_valid    <= 1'b0;
            bus.img         <= 8'd0;
            bus.ker         <= 8'd0;
            bus.weight      <= 8'd0;
            bus.res_valid   <= 1'b0;
            bus.res_data    <= 10'd0;
            bus.res_timeout <= 1'b0;
        end else begin
            bus.in_valid  <= 1'b0;
            bus.img       <= 8'd0;
            bus.ker       <= 8'd0;
            bus.weight    <= 8'd0;
            bus.res_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        // beat counts the next beat to fetch; beat 0 goes out right now
                        state        <= S_SEND;
                        beat         <= 7'd1;
                        bus.busy     <= 1'b1;
                        bus.in_valid <= 1'b1;
                        bus.img      <= img_nxt;
                        bus.ker      <= ker_nxt;
                        bus.weight   <= w_nxt;
                    end
                end
                S_SEND: begin
                    if (beat == 7'(NBEAT)) begin
                        state <= S_WAIT;
                        wcnt  <= '0;
                    end else begin
                        beat         <= beat + 7'd1;
                        bus.in_valid <= 1'b1;
                        bus.img      <= img_nxt;
                        bus.ker      <= ker_nxt;
                        bus.weight   <= w_nxt;
                    end
                end
                S_WAIT: begin
                    if (bus.out_valid) begin
                        state           <= S_DONE;
                        bus.res_valid   <= 1'b1;
                        bus.res_data    <= bus.out_data;
                        bus.res_timeout <= 1'b0;
                    end else if (wcnt == WW'(TIMEOUT - 1)) begin
                        state           <= S_DONE;
                        bus.res_valid   <= 1'b1;
                        bus.res_data    <= 10'd0;
                        bus.res_timeout <= 1'b1;
                    end else begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_snn_stim_tx.sv
// Scoreboard bench for snn_stim_tx: the driver predicts beats/results from a byte-array
// model of the job buffer; a negedge monitor pops and compares whatever the DUT presents.
module tb_snn_stim_tx;
    localparam int TO = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    snn_stim_tx_if bus();
    snn_stim_tx #(.TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { int cyc; logic [7:0] img; logic [7:0] ker; logic [7:0] w; } beat_t;
    typedef struct { int cyc; logic [9:0] data; logic to; } res_t;

    beat_t beat_q[$];
    res_t  res_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    logic [7:0] m_img [72];
    logic [7:0] m_ker [9];
    logic [7:0] m_w   [4];
    bit         m_idle = 1'b1;
    int         bsy_lo = 1, bsy_hi = 0;
    logic [9:0] h_data = 10'd0;
    logic       h_to   = 1'b0;
    int         jc, jd, jrc;
    logic [9:0] jod;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        beat_t b;
        res_t  r;
        if (rst_n) begin
            chk("busy", 32'(bus.busy), 32'(cyc >= bsy_lo && cyc <= bsy_hi));
            if (bus.in_valid) begin
                if (beat_q.size() == 0) chk("unexp_beat", 32'(bus.in_valid), 32'd0);
                else begin
                    b = beat_q.pop_front();
                    chk("beat_cyc", 32'(cyc), 32'(b.cyc));
                    chk("img", 32'(bus.img), 32'(b.img));
                    chk("ker", 32'(bus.ker), 32'(b.ker));
                    chk("weight", 32'(bus.weight), 32'(b.w));
                end
            end else begin
                chk("idle_bus", 32'({bus.img, bus.ker, bus.weight}), 32'd0);
            end
            if (bus.res_valid) begin
                if (res_q.size() == 0) chk("unexp_res", 32'(bus.res_valid), 32'd0);
                else begin
                    r = res_q.pop_front();
                    chk("res_cyc", 32'(cyc), 32'(r.cyc));
                    chk("res_data", 32'(bus.res_data), 32'(r.data));
                    chk("res_timeout", 32'(bus.res_timeout), 32'(r.to));
                    h_data = r.data;
                    h_to   = r.to;
                end
            end else begin
                chk("res_hold", 32'({bus.res_timeout, bus.res_data}), 32'({h_to, h_data}));
            end
        end
    end

    // Buffer model: writes land only while no job is running and only in range.
    function automatic void mwr(input logic [1:0] s, input logic [6:0] a, input logic [7:0] d);
        if (!m_idle) return;
        case (s)
            2'd0: if (a < 7'd72) m_img[int'(a)] = d;
            2'd1: if (a < 7'd9)  m_ker[int'(a)] = d;
            2'd2: if (a < 7'd4)  m_w[int'(a)]   = d;
            default: ;
        endcase
    endfunction

    task automatic to_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] s, input logic [6:0] a, input logic [7:0] d);
        bus.ld_valid = 1'b1; bus.ld_sel = s; bus.ld_addr = a; bus.ld_data = d;
        mwr(s, a, d);
        to_cyc(cyc + 1);
        bus.ld_valid = 1'b0;
    endtask

    task automatic launch(input int d, input logic [9:0] od, input bit ld,
                          input logic [1:0] s, input logic [6:0] a, input logic [7:0] dd);
        beat_t b;
        res_t  r;
        int    last;
        if (ld) begin
            bus.ld_valid = 1'b1; bus.ld_sel = s; bus.ld_addr = a; bus.ld_data = dd;
            mwr(s, a, dd);
        end
        bus.start = 1'b1;
        jc = cyc; jd = d; jod = od;
        for (int n = 0; n < 72; n++) begin
            b.cyc = jc + 1 + n;
            b.img = m_img[n];
            b.ker = (n < 9) ? m_ker[n] : 8'd0;
            b.w   = (n < 4) ? m_w[n]   : 8'd0;
            beat_q.push_back(b);
        end
        last = jc + 72;
        if (d >= 1 && d <= TO) begin
            r.cyc = last + d + 1; r.data = od; r.to = 1'b0;
        end else begin
            r.cyc = last + TO + 1; r.data = 10'd0; r.to = 1'b1;
        end
        jrc = r.cyc;
        res_q.push_back(r);
        bsy_lo = jc + 1; bsy_hi = jrc; m_idle = 1'b0;
        to_cyc(jc + 1);
        bus.start = 1'b0; bus.ld_valid = 1'b0;
    endtask

    // SNN side: optional stray out_valid during SEND, then the real response jd cycles after the last beat.
    task automatic finish(input bit noise);
        int last, nb;
        last = jc + 72;
        if (noise) begin
            nb = int'($urandom_range(0, 70));
            to_cyc(jc + 1 + nb);
            bus.out_valid = 1'b1; bus.out_data = 10'($urandom);
            to_cyc(cyc + 1);
            bus.out_valid = 1'b0;
        end
        if (jd > 0) begin
            to_cyc(last + jd);
            bus.out_valid = 1'b1; bus.out_data = jod;
            to_cyc(cyc + 1);
            bus.out_valid = 1'b0;
        end
        to_cyc(jrc + 1);
        m_idle = 1'b1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
        chk({nm, "_in_valid"}, 32'(bus.in_valid), 32'd0);
        chk({nm, "_img"}, 32'(bus.img), 32'd0);
        chk({nm, "_ker"}, 32'(bus.ker), 32'd0);
        chk({nm, "_weight"}, 32'(bus.weight), 32'd0);
        chk({nm, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({nm, "_res_data"}, 32'(bus.res_data), 32'd0);
        chk({nm, "_res_timeout"}, 32'(bus.res_timeout), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int dl [6] = '{0, 1, 4, 16, 17, 20};
        int d;
        bus.ld_valid = 1'b0; bus.ld_sel = 2'd0; bus.ld_addr = 7'd0; bus.ld_data = 8'd0;
        bus.start = 1'b0; bus.out_valid = 1'b0; bus.out_data = 10'd0;
        #1 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_zero("reset");
        rst_n = 1'b1;
        to_cyc(cyc + 1);

        for (int i = 0; i < 72; i++) wr(2'd0, 7'(i), 8'(i));
        for (int k = 0; k < 9; k++)  wr(2'd1, 7'(k), 8'(k + 1));
        for (int w = 0; w < 4; w++)  wr(2'd2, 7'(w), 8'(10 + w));

        launch(4, 10'd345, 1'b0, 2'd0, 7'd0, 8'd0); finish(1'b0);
        launch(0, 10'd0, 1'b0, 2'd0, 7'd0, 8'd0);   finish(1'b0);

        // start and a load arriving mid-stream must both be dropped
        launch(4, 10'd100, 1'b0, 2'd0, 7'd0, 8'd0);
        to_cyc(jc + 11);
        bus.start = 1'b1;
        bus.ld_valid = 1'b1; bus.ld_sel = 2'd0; bus.ld_addr = 7'd5; bus.ld_data = 8'hFF;
        mwr(2'd0, 7'd5, 8'hFF);
        to_cyc(cyc + 1);
        bus.start = 1'b0; bus.ld_valid = 1'b0;
        finish(1'b0);
        launch(3, 10'd7, 1'b0, 2'd0, 7'd0, 8'd0); finish(1'b0);

        wr(2'd0, 7'd72, 8'hAA); wr(2'd1, 7'd9, 8'hAA); wr(2'd2, 7'd4, 8'hAA);
        wr(2'd3, 7'd0, 8'hAA);  wr(2'd3, 7'd5, 8'hAA);
        launch(2, 10'd513, 1'b0, 2'd0, 7'd0, 8'd0); finish(1'b0);

        bus.out_valid = 1'b1; bus.out_data = 10'd999;
        to_cyc(cyc + 1);
        bus.out_valid = 1'b0;
        to_cyc(cyc + 2);
        launch(5, 10'd222, 1'b0, 2'd0, 7'd0, 8'd0); finish(1'b1);

        // asynchronous reset in the middle of beat 40
        launch(4, 10'd1, 1'b0, 2'd0, 7'd0, 8'd0);
        to_cyc(jc + 41);
        #2 rst_n = 1'b0;
        #1 chk_zero("midreset");
        beat_q.delete(); res_q.delete();
        bsy_lo = 1; bsy_hi = 0; h_data = 10'd0; h_to = 1'b0; m_idle = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        to_cyc(cyc + 1);
        launch(4, 10'd2, 1'b0, 2'd0, 7'd0, 8'd0); finish(1'b0);

        launch(4, 10'd11, 1'b0, 2'd0, 7'd0, 8'd0); finish(1'b0);
        launch(6, 10'd12, 1'b0, 2'd0, 7'd0, 8'd0); finish(1'b0);

        launch(4, 10'd77, 1'b1, 2'd0, 7'd0, 8'h5A); finish(1'b0);

        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < 3; k++)
                wr(2'($urandom_range(0, 3)), 7'($urandom_range(0, 79)), 8'($urandom));
            d = ($urandom_range(0, 1) == 1) ? dl[$urandom_range(0, 5)] : int'($urandom_range(1, 20));
            launch(d, 10'($urandom), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 2)), 7'($urandom_range(0, 8)), 8'($urandom));
            finish(1'($urandom_range(0, 1)));
        end

        to_cyc(cyc + 3);
        chk("beat_q_drained", 32'(beat_q.size()), 32'd0);
        chk("res_q_drained", 32'(res_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/snn_stim_tx.md
# snn_stim_tx

Stimulus transmitter for the SNN inference block; it drives the SNN input side of the protocol. It holds one complete job in a local buffer: 72 image bytes (two 6x6 images), 9 kernel bytes and 4 weight bytes, loaded through a simple write port. On `start` it streams the job onto `in_valid`/`img`/`ker`/`weight` in the exact cycle order the SNN consumes. It then waits for the SNN's `out_valid`/`out_data`, and returns the result, or a timeout, to the host side.

## Interface
- `TIMEOUT`, 16: maximum cycles to wait for `out_valid` after the last `in_valid` cycle.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ld_valid`  in  1  buffer write strobe.
- `ld_sel`  in  2  target: 0 = image, 1 = kernel, 2 = weight, 3 = reserved (write ignored).
- `ld_addr`  in  7  index within the target. Image 0..71 (0..35 image 1 row-major, 36..71 image 2). Kernel 0..8 row-major. Weight 0..3 row-major.
- `ld_data`  in  8  byte to write.
- `start`  in  1  single-cycle job launch.
- `busy`  out  1  high from the cycle after `start` is accepted until the cycle `res_valid` pulses, inclusive.
- `in_valid`  out  1  SNN input valid.
- `img`  out  8  SNN image byte.
- `ker`  out  8  SNN kernel byte.
- `weight`  out  8  SNN weight byte.
- `out_valid`  in  1  SNN result valid.
- `out_data`  in  10  SNN result.
- `res_valid`  out  1  one-cycle pulse: job finished.
- `res_data`  out  10  captured `out_data`; 0 on timeout.
- `res_timeout`  out  1  qualifies `res_valid`: 1 means no `out_valid` arrived within `TIMEOUT`.

## Operation
- States: IDLE, SEND, WAIT, DONE.
- **IDLE**
  - A write with `ld_valid`=1 and an in-range address stores `ld_data`.
  - Out-of-range addresses and `ld_sel`=3 are ignored.
  - `start`=1 moves the block to SEND and clears the 7-bit beat counter.
- **SEND**: `in_valid`=1 for beats 0..71.
  - `img` = image[beat].
  - `ker` = kernel[beat] for beats 0..8, else 0.
  - `weight` = weight[beat] for beats 0..3, else 0.
  - After beat 71 the block moves to WAIT and clears the wait counter.
- **WAIT**
  - `out_valid`=1: capture `out_data` into `res_data`, set `res_timeout`=0, go to DONE.
  - Otherwise the wait counter increments. When the counter equals `TIMEOUT`-1 with no `out_valid`, set `res_data`=0, `res_timeout`=1, go to DONE.
- **DONE**: `res_valid`=1 for one cycle, then IDLE. `res_data`/`res_timeout` hold until the next job's DONE.
- Whenever `in_valid`=0, `img`, `ker` and `weight` are driven to 0. No stale data is ever presented.
- `start` outside IDLE is ignored (no queuing).
- `ld_valid` outside IDLE is ignored, so the buffer is stable during a job.
- `out_valid` in IDLE, SEND or DONE is ignored.
- Same-cycle `ld_valid` and `start` in IDLE: the write completes and `start` is accepted. The streamed job uses the written value.
- The buffer is not cleared by reset. Contents are undefined until loaded, and a job may be re-sent without reloading.

## Timing
- Reset (asynchronous, immediate, including mid-job):
  - State returns to IDLE.
  - `busy`, `in_valid`, `img`, `ker`, `weight`, `res_valid`, `res_data`, `res_timeout` all go to 0.
  - Counters are cleared; the buffer is retained.
- All outputs are registered.
- `start` is sampled at edge t. Then `busy` and `in_valid` are 1 during cycles t+1..t+72. Beat n is presented in cycle t+1+n.
- `in_valid` is exactly 72 consecutive cycles, with no gaps.
- `out_valid` sampled at edge u in WAIT gives `res_valid`=1 in cycle u+1.
  - With the SNN latency, `out_valid` arrives about 4 cycles after the last beat.
  - Typical start-to-`res_valid`: about 78 cycles.
- Timeout: `res_valid` appears `TIMEOUT`+1 cycles after the last `in_valid` cycle.
- A new `start` is accepted in the cycle after `res_valid`, which is the minimum job-to-job gap.

## Test plan
- Load image[i]=i, kernel[k]=k+1, weight[w]=10+w, then pulse `start`.
  - Bench checks: `in_valid` high for exactly 72 cycles starting one cycle after `start`; `img` sequence 0..71.
  - `ker` 1..9 then 0; `weight` 10..13 then 0.
  - Model SNN returns `out_valid` with `out_data`=10'd345 four cycles later.
  - Required: `res_valid` pulse with `res_data`=345, `res_timeout`=0.
- No `out_valid` from the bench, `TIMEOUT`=16 -> `res_valid` 17 cycles after the last beat, `res_data`=0, `res_timeout`=1, then IDLE.
- Pulse `start`, and `ld_valid` writing image[5]=8'hFF, during SEND beat 10 -> both ignored. Beat 5 of the next job still carries the original value.
- Write image[72], kernel[9], weight[4] and `ld_sel`=3 with value 8'hAA -> no stored byte changes; a subsequent stream matches the previous load.
- Assert `rst_n`=0 at beat 40 -> all outputs 0 immediately. After release, `start` streams the full job from beat 0 with the buffer intact.
- `out_valid` pulsed in IDLE and during SEND -> no `res_valid`. Two back-to-back jobs, with `start` in the cycle after `res_valid`, return both results correctly.
